// File: rtl/cpu64_most_advanced_top.sv
// Single-issue 64-bit core: async-read instruction/data arrays, 16x64 register file,
// one instruction executed and retired per rising edge until HALT.
module cpu64_most_advanced_top #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_we,
    input  logic [7:0]  imem_addr,
    input  logic [31:0] imem_wdata,
    output logic [63:0] pc,
    output logic        halted,
    output logic        retire_valid,
    output logic [63:0] retire_pc,
    output logic        retire_we,
    output logic [3:0]  retire_rd,
    output logic [63:0] retire_data
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LUI  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;

    logic [31:0] imem_q [IMEM_DEPTH];
    // Data memory must read zero before any store; neither memory is touched by reset.
    logic [63:0] dmem_q [DMEM_DEPTH] = '{default: 64'd0};
    logic [63:0] rf_q [16];

    logic [63:0] pc_q;
    logic        halted_q;
    logic        retire_valid_q;
    logic [63:0] retire_pc_q;
    logic        retire_we_q;
    logic [3:0]  retire_rd_q;
    logic [63:0] retire_data_q;

    logic [31:0]    instr;
    logic [3:0]     op;
    logic [3:0]     rd;
    logic [63:0]    simm;
    logic [63:0]    src_a;
    logic [63:0]    src_b;
    logic [DAW-1:0] ea_idx;
    logic [63:0]    pc_inc;
    logic [63:0]    pc_d;
    logic [63:0]    result_d;
    logic           wr_en_d;
    logic           st_en_d;
    logic           rd_we;
    logic           exec;

    assign instr  = imem_q[pc_q[IAW-1:0]];
    assign op     = instr[31:28];
    assign rd     = instr[27:24];
    assign simm   = {{48{instr[15]}}, instr[15:0]};
    assign src_a  = rf_q[instr[23:20]];
    assign src_b  = rf_q[instr[19:16]];
    // Only the low address bits matter, so the effective address is formed at index width.
    assign ea_idx = src_a[DAW-1:0] + simm[DAW-1:0];
    assign pc_inc = pc_q + 64'd1;
    assign exec   = !rst && !halted_q;

    always_comb begin
        result_d = '0;
        wr_en_d  = 1'b0;
        st_en_d  = 1'b0;
        pc_d     = pc_inc;
        case (op)
            OP_ADD:  begin result_d = src_a + src_b;         wr_en_d = 1'b1; end
            OP_SUB:  begin result_d = src_a - src_b;         wr_en_d = 1'b1; end
            OP_AND:  begin result_d = src_a & src_b;         wr_en_d = 1'b1; end
            OP_OR:   begin result_d = src_a | src_b;         wr_en_d = 1'b1; end
            OP_XOR:  begin result_d = src_a ^ src_b;         wr_en_d = 1'b1; end
            OP_ADDI: begin result_d = src_a + simm;          wr_en_d = 1'b1; end
            OP_LUI:  begin result_d = simm << 16;            wr_en_d = 1'b1; end
            OP_SHL:  begin result_d = src_a << src_b[5:0];   wr_en_d = 1'b1; end
            OP_SHR:  begin result_d = src_a >> src_b[5:0];   wr_en_d = 1'b1; end
            OP_LD:   begin result_d = dmem_q[ea_idx];        wr_en_d = 1'b1; end
            OP_ST:   st_en_d = 1'b1;
            OP_BEQ:  if (src_a == src_b) pc_d = pc_inc + simm;
            OP_JMP:  pc_d = pc_inc + simm;
            OP_HALT: pc_d = pc_q;
            default: ;
        endcase
    end

    assign rd_we = wr_en_d && (rd != 4'd0);

    always_ff @(posedge clk) begin
        if (imem_we) imem_q[imem_addr[IAW-1:0]] <= imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (exec && st_en_d) dmem_q[ea_idx] <= src_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= '0;
            halted_q       <= 1'b0;
            retire_valid_q <= 1'b0;
            retire_pc_q    <= '0;
            retire_we_q    <= 1'b0;
            retire_rd_q    <= '0;
            retire_data_q  <= '0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else if (!halted_q) begin
            pc_q           <= pc_d;
            halted_q       <= (op == OP_HALT);
            retire_valid_q <= 1'b1;
            retire_pc_q    <= pc_q;
            retire_we_q    <= rd_we;
            retire_rd_q    <= rd_we ? rd : 4'd0;
            retire_data_q  <= rd_we ? result_d : 64'd0;
            if (rd_we) rf_q[rd] <= result_d;
        end else begin
            retire_valid_q <= 1'b0;
        end
    end

    assign pc           = pc_q;
    assign halted       = halted_q;
    assign retire_valid = retire_valid_q;
    assign retire_pc    = retire_pc_q;
    assign retire_we    = retire_we_q;
    assign retire_rd    = retire_rd_q;
    assign retire_data  = retire_data_q;
endmodule

// File: tb/tb_cpu64_most_advanced_top.sv
// Bench for cpu64_most_advanced_top: an instruction-level interpreter predicts every
// cycle's pc/halted/retire outputs for directed and random programs.
module tb_cpu64_most_advanced_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_addr = '0;
    logic [31:0] imem_wdata = '0;
    logic [63:0] pc;
    logic        halted;
    logic        retire_valid;
    logic [63:0] retire_pc;
    logic        retire_we;
    logic [3:0]  retire_rd;
    logic [63:0] retire_data;

    cpu64_most_advanced_top dut (
        .clk(clk), .rst(rst), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .pc(pc), .halted(halted),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_we(retire_we),
        .retire_rd(retire_rd), .retire_data(retire_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_im [256];
    logic [63:0] m_rf [16];
    logic [63:0] m_dm [256];
    logic [63:0] m_pc;
    bit          m_halted;
    bit          e_valid, e_we, e_full, e_dchk;
    logic [63:0] e_rpc, e_data;
    logic [3:0]  e_rd;
    logic [31:0] prog [$];

    function automatic logic [31:0] enc(int op, int rd, int rs1, int rs2, int imm);
        logic [31:0] w;
        w = {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] rand_instr();
        int op;
        int imm;
        op = int'($urandom_range(0, 15));
        if (op == 14 && $urandom_range(0, 3) != 0) op = 6;
        imm = int'($urandom_range(0, 31)) - 16;
        return enc(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), imm);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_halted = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        e_valid = 0; e_we = 0; e_rpc = '0; e_rd = '0; e_data = '0;
        e_full = 1; e_dchk = 1;
    endtask

    // ISA semantics straight from the instruction table, one instruction at a time.
    task automatic model_step();
        logic [31:0] ins;
        logic [63:0] a, b, si, r, ea;
        logic [3:0]  rd;
        bit          w;
        if (m_halted) begin
            e_valid = 0; e_full = 0;
            return;
        end
        ins = m_im[m_pc[7:0]];
        rd  = ins[27:24];
        a   = m_rf[ins[23:20]];
        b   = m_rf[ins[19:16]];
        si  = {{48{ins[15]}}, ins[15:0]};
        ea  = a + si;
        r = '0; w = 0;
        e_valid = 1; e_full = 1; e_rpc = m_pc;
        m_pc = m_pc + 64'd1;
        case (ins[31:28])
            4'h1: begin r = a + b; w = 1; end
            4'h2: begin r = a - b; w = 1; end
            4'h3: begin r = a & b; w = 1; end
            4'h4: begin r = a | b; w = 1; end
            4'h5: begin r = a ^ b; w = 1; end
            4'h6: begin r = a + si; w = 1; end
            4'h7: begin r = si << 16; w = 1; end
            4'h8: begin r = a << b[5:0]; w = 1; end
            4'h9: begin r = a >> b[5:0]; w = 1; end
            4'hA: begin r = m_dm[ea[7:0]]; w = 1; end
            4'hB: m_dm[ea[7:0]] = b;
            4'hC: if (a == b) m_pc = m_pc + si;
            4'hD: m_pc = m_pc + si;
            4'hE: begin m_halted = 1; m_pc = e_rpc; end
            default: ;
        endcase
        if (w && rd != 4'd0) m_rf[rd] = r;
        e_we   = w && (rd != 4'd0);
        e_rd   = e_we ? rd : 4'd0;
        e_data = e_we ? r : 64'd0;
        e_dchk = e_we || !w;
    endtask

    task automatic cycle(input string ph);
        if (rst) model_reset(); else model_step();
        if (imem_we) m_im[imem_addr] = imem_wdata;
        @(posedge clk);
        #1;
        chk({ph, ".retire_valid"}, 64'(retire_valid), 64'(e_valid));
        chk({ph, ".pc"}, pc, m_pc);
        chk({ph, ".halted"}, 64'(halted), 64'(m_halted));
        if (e_full) begin
            chk({ph, ".retire_pc"}, retire_pc, e_rpc);
            chk({ph, ".retire_we"}, 64'(retire_we), 64'(e_we));
            chk({ph, ".retire_rd"}, 64'(retire_rd), 64'(e_rd));
            if (e_dchk) chk({ph, ".retire_data"}, retire_data, e_data);
        end
    endtask

    task automatic load_prog(input string ph);
        rst = 1'b1;
        foreach (prog[i]) begin
            imem_we = 1'b1; imem_addr = 8'(i); imem_wdata = prog[i];
            cycle(ph);
        end
        imem_we = 1'b0;
        cycle(ph);
        rst = 1'b0;
    endtask

    task automatic run(input string ph, input int n);
        rst = 1'b0;
        repeat (n) cycle(ph);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_dm[i] = '0;

        // Reset with fully random imem, then run it as a random program.
        prog.delete();
        for (int i = 0; i < 256; i++) prog.push_back(rand_instr());
        load_prog("reset");
        cycle("rand0");
        chk("rand0.first_retire_pc", retire_pc, 64'd0);
        run("rand0", 60);

        // ALU chain.
        prog = '{enc(6,1,0,0,5), enc(6,2,0,0,-3), enc(1,3,1,2,0), enc(2,4,2,1,0),
                 enc(8,5,1,1,0), enc(14,0,0,0,0)};
        load_prog("alu");
        cycle("alu"); chk("alu.r1", retire_data, 64'd5);
        cycle("alu"); chk("alu.r2", retire_data, 64'hFFFF_FFFF_FFFF_FFFD);
        cycle("alu"); chk("alu.r3", retire_data, 64'd2);
        cycle("alu"); chk("alu.r4", retire_data, 64'hFFFF_FFFF_FFFF_FFF8);
        cycle("alu"); chk("alu.r5", retire_data, 64'd160);
        cycle("alu"); chk("alu.halt_pc", pc, 64'd5);
        chk("alu.halt_we", 64'(retire_we), 64'd0);
        run("alu_idle", 3);

        // Store/load, including a never-written location.
        prog = '{enc(6,1,0,0,16'h1234), enc(11,0,0,1,7), enc(10,2,0,0,7),
                 enc(10,3,0,0,8), enc(14,0,0,0,0)};
        load_prog("mem");
        run("mem", 3); chk("mem.ld_r2", retire_data, 64'h1234);
        run("mem", 1); chk("mem.ld_r3", retire_data, 64'd0);
        run("mem", 2);

        // Branches: not-taken, then taken skipping pc 3.
        prog = '{enc(6,1,0,0,1), enc(12,0,1,0,5), enc(12,0,1,1,1), enc(6,2,0,0,9),
                 enc(6,3,0,0,7), enc(14,0,0,0,0)};
        load_prog("ctl");
        run("ctl", 4);
        chk("ctl.skip_pc", retire_pc, 64'd4);
        chk("ctl.r3", retire_data, 64'd7);
        run("ctl", 2);

        // JMP -1 spins on pc 0.
        prog = '{enc(13,0,0,0,-1)};
        load_prog("jmp");
        for (int i = 0; i < 5; i++) begin
            cycle("jmp");
            chk("jmp.retire_pc", retire_pc, 64'd0);
        end

        // r0 write discard, r0 read, then HALT and idle.
        prog = '{enc(6,0,0,0,9), enc(1,1,0,0,0), enc(14,0,0,0,0)};
        load_prog("r0");
        cycle("r0"); chk("r0.we", 64'(retire_we), 64'd0);
        cycle("r0"); chk("r0.read", retire_data, 64'd0);
        run("r0_halt", 11);
        chk("r0.idle_valid", 64'(retire_valid), 64'd0);
        chk("r0.idle_pc", pc, 64'd2);

        // Loop with mid-run reset, then a same-edge rewrite of the executing word.
        prog = '{enc(6,1,1,0,1), enc(13,0,0,0,-2)};
        load_prog("loop");
        run("loop", 7);
        rst = 1'b1; cycle("loop_rst");
        cycle("loop_rerun") ; rst = 1'b0;
        cycle("loop_rerun");
        chk("loop.rerun_pc", retire_pc, 64'd0);
        chk("loop.rerun_r1", retire_data, 64'd1);
        run("loop_rerun", 5);
        imem_we = 1'b1; imem_addr = 8'd0; imem_wdata = enc(6,1,1,0,100);
        cycle("selfmod");
        imem_we = 1'b0;
        run("selfmod", 6);

        // Short random programs on top of existing memory contents.
        for (int r = 0; r < 3; r++) begin
            prog.delete();
            for (int i = 0; i < 32; i++) prog.push_back(rand_instr());
            load_prog("rand");
            run("rand", 60);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu64_most_advanced_top.md
# cpu64_most_advanced_top

Top-level 64-bit processor block (module `cpu64_most_advanced_top`), the system-level wrapper brought up by the CPU smoke bench with only a clock and reset. It holds an instruction memory, a data memory, a 16×64-bit register file and a single-issue execute core that retires at most one instruction per cycle. A program-load port and a retire/debug port make it loadable and observable.

## Interface
- `IMEM_DEPTH`, 256: instruction words (32-bit); fetch index = `pc` mod IMEM_DEPTH.
- `DMEM_DEPTH`, 256: data words (64-bit); address = effective address mod DMEM_DEPTH.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_we` in 1: write strobe for the instruction memory.
- `imem_addr` in 8: word index for program loading.
- `imem_wdata` in 32: instruction word to write.
- `pc` out 64: address of the next instruction to execute.
- `halted` out 1: set by HALT; sticky until reset.
- `retire_valid` out 1: one instruction retired on the last edge.
- `retire_pc` out 64: address of the retired instruction.
- `retire_we` out 1: retired instruction wrote a register other than r0.
- `retire_rd` out 4: destination register.
- `retire_data` out 64: value written.

## Operation
- Instruction fields:
  - [31:28] opcode
  - [27:24] rd
  - [23:20] rs1
  - [19:16] rs2
  - [15:0] imm, sign-extended to 64 bits (`simm`).
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs1+rs2. 2 SUB rd=rs1−rs2 (both mod 2^64).
  - 3 AND, 4 OR, 5 XOR.
  - 6 ADDI rd=rs1+simm.
  - 7 LUI rd=simm<<16.
  - 8 SHL rd=rs1<<rs2[5:0]. 9 SHR, logical, rd=rs1>>rs2[5:0].
  - A LD rd=dmem[rs1+simm].
  - B ST dmem[rs1+simm]=rs2.
  - C BEQ: if rs1==rs2 then pc=pc+1+simm, else pc+1.
  - D JMP pc=pc+1+simm.
  - E HALT.
  - F executes as NOP.
- PC counts instruction words. Non-control instructions advance pc by 1. All PC arithmetic is mod 2^64.
- r0 reads as 0. Writes to r0 are discarded and give `retire_we`=0.
- Instructions that write no register (NOP, ST, BEQ, JMP, HALT, F) give `retire_we`=0, `retire_rd`=0, `retire_data`=0.
- Source operands are read from the register file before the edge's write, so back-to-back dependent instructions need no stall or forwarding.
- HALT:
  - retires normally (`retire_valid`=1, `retire_we`=0) and sets `halted`.
  - `pc` stays at the HALT address.
  - No further execution or memory writes until reset.
- Instruction memory:
  - written whenever `imem_we`=1, in reset or not.
  - Not cleared by reset.
  - A write to the address executing on the same edge takes effect from the next fetch; the current execute uses the old word.
- Data memory is not cleared by reset. Loading a never-written location returns 0; the memory is initialised to zero at time 0.

## Timing
- While `rst`=1 at an edge:
  - `pc`=0, all registers 0, `halted`=0.
  - `retire_valid`, `retire_we`=0; `retire_pc`, `retire_rd`, `retire_data`=0.
  - No execute and no data-memory write.
- Each edge with `rst`=0 and `halted`=0 executes exactly one instruction, `imem[pc]`. Register, data-memory, `pc` and retire outputs all update on that edge, giving one-cycle latency and a throughput of 1 instruction per cycle.
- `retire_valid` is high for every cycle following an executing edge. It is low in reset and in all cycles after the HALT retire cycle.
- Reset asserted mid-program takes priority over execute on that edge. Execution restarts from address 0 on the first edge after `rst` deasserts.
- A load sees a store made by the immediately preceding instruction.

## Test plan
- Reset: hold `rst` high for 2 edges with random imem contents → `pc`=0, `halted`=0, `retire_valid`=0. Release → first retire has `retire_pc`=0.
- ALU chain. Program:
  - ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SUB r4,r2,r1; SHL r5,r1,r1; HALT.
  - Required retires: r1=5, r2=0xFFFF_FFFF_FFFF_FFFD, r3=2, r4=0xFFFF_FFFF_FFFF_FFF8, r5=160.
  - Then HALT retires with `retire_we`=0, `halted`=1, `pc`=5.
- Memory. Program:
  - ADDI r1,r0,0x1234; ST [r0+7],r1; LD r2,[r0+7]; LD r3,[r0+8].
  - Required: r2=0x1234, r3=0.
- Control flow. Program:
  - ADDI r1,r0,1; BEQ r1,r0,+5 (not taken); BEQ r1,r1,+1 (taken, skips pc 3); ADDI r2,r0,9; ADDI r3,r0,7; HALT.
  - Required: no retire at pc 3, r3=7 retired at pc 4, r2 stays 0.
  - Also: JMP −1 at pc 0 → `retire_pc` 0 every cycle.
- r0/HALT: ADDI r0,r0,9 → `retire_we`=0. Then read r0 via ADD r1,r0,r0 → r1=0. After HALT, 10 idle cycles → `retire_valid`=0 and `pc` constant.
- Mid-run reset: assert `rst` during a loop → on the next edge `pc`=0 and registers are cleared. Imem contents are preserved and the program reruns identically.
